// File: rtl/pwm_dt_pkg.sv
// Shared constants for the dead-time PWM driver: phase FSM state codes and
// the minimum dead-time count.
package pwm_dt_pkg;

    localparam int unsigned ST_W = 2;

    // Per-phase FSM state codes
    localparam logic [ST_W-1:0] ST_OFF  = 2'd0;
    localparam logic [ST_W-1:0] ST_DEAD = 2'd1;
    localparam logic [ST_W-1:0] ST_HIGH = 2'd2;
    localparam logic [ST_W-1:0] ST_LOW  = 2'd3;

    // A programmed dead time of zero is raised to this floor
    localparam int unsigned DT_FLOOR = 1;

endpackage

// File: rtl/pwm_dt_phase.sv
// One half-bridge phase: OFF/DEAD/HIGH/LOW FSM with a dead-time down-counter.
// Ports:
//   clk, reset_n     - clock, synchronous active-low reset
//   run              - run condition; 0 sends the phase to OFF on the next edge
//   cmd              - requested side (1 = high side, 0 = low side)
//   dt_cycles        - dead time in clk cycles, sampled on entry to DEAD
//   udrive, ldrive   - registered high/low gate drives
module pwm_dt_phase
    import pwm_dt_pkg::*;
#(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    input  logic            cmd,
    input  logic [DT_W-1:0] dt_cycles,
    output logic            udrive,
    output logic            ldrive
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nx;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nx;
    logic [DT_W-1:0] dt_load_c;

    // Dead time floored so that a zero setting still leaves one idle cycle
    assign dt_load_c = (dt_cycles < DT_W'(DT_FLOOR)) ? DT_W'(DT_FLOOR) : dt_cycles;

    // Next-state and counter logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!run) begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nx = ST_DEAD;
                    cnt_nx   = dt_load_c;
                end
                ST_DEAD: begin
                    // Side chosen from cmd at expiry; toggles during DEAD are ignored
                    if (cnt <= DT_W'(DT_FLOOR)) begin
                        state_nx = cmd ? ST_HIGH : ST_LOW;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - DT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!cmd) begin
                        state_nx = ST_DEAD;
                        cnt_nx   = dt_load_c;
                    end
                end
                ST_LOW: begin
                    if (cmd) begin
                        state_nx = ST_DEAD;
                        cnt_nx   = dt_load_c;
                    end
                end
                default: begin
                    state_nx = ST_OFF;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // State, counter and drive registers; drives decode the next state so
    // they change on the same edge as the state itself
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_OFF;
            cnt    <= '0;
            udrive <= 1'b0;
            ldrive <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            udrive <= (state_nx == ST_HIGH);
            ldrive <= (state_nx == ST_LOW);
        end
    end

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-phase half-bridge gate driver with programmable dead time and a
// sticky fault trip.
// Ports:
//   clk, reset_n   - 50 MHz clock, synchronous active-low reset
//   enable         - 0 forces all drivers off
//   phase_cmd      - requested side per phase (MSB = phase A)
//   dt_cycles      - dead time in clk cycles
//   fault_n        - synchronised active-low trip input
//   fault_clr      - pulse clearing the latched fault (only while fault_n=1)
//   udrive, ldrive - registered high/low side gate drives
//   fault_latched  - sticky trip status
module pwm_deadtime
    import pwm_dt_pkg::*;
#(
    parameter int unsigned N_PHASES = 3,
    parameter int unsigned DT_W     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [N_PHASES-1:0] phase_cmd,
    input  logic [DT_W-1:0]     dt_cycles,
    input  logic                fault_n,
    input  logic                fault_clr,
    output logic [N_PHASES-1:0] udrive,
    output logic [N_PHASES-1:0] ldrive,
    output logic                fault_latched
);

    logic run_c;

    // fault_n is included directly so a trip kills the drives on the same
    // edge that latches it
    assign run_c = enable & fault_n & ~fault_latched;

    // Sticky fault latch; an active trip overrides a clear request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fault_latched <= 1'b0;
        end else if (!fault_n) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

    // One independent FSM per phase
    for (genvar i = 0; i < N_PHASES; i++) begin : g_phase
        pwm_dt_phase #(
            .DT_W (DT_W)
        ) u_phase (
            .clk       (clk),
            .reset_n   (reset_n),
            .run       (run_c),
            .cmd       (phase_cmd[i]),
            .dt_cycles (dt_cycles),
            .udrive    (udrive[i]),
            .ldrive    (ldrive[i])
        );
    end

endmodule
